// File: rtl/execute_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_mc_if
// Description : Handshake/bus bundle between ID/EX, the EX stage and EX/MEM.
//               The master side drives the EX inputs and observes the
//               registered EX/MEM outputs. The slave side is the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_mc_if #(
  parameter int N = 64
);
  logic         valid_E;
  logic         flush_E;
  logic         AluSrc;
  logic         MulOp;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic         stall_E;
  logic         valid_M;
  logic [N-1:0] PCBranch_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;

  modport master (
    output valid_E, flush_E, AluSrc, MulOp, AluControl,
           PC_E, signImm_E, readData1_E, readData2_E,
    input  stall_E, valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );

  modport slave (
    input  valid_E, flush_E, AluSrc, MulOp, AluControl,
           PC_E, signImm_E, readData1_E, readData2_E,
    output stall_E, valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );
endinterface
`default_nettype wire

// File: rtl/execute_mc.sv
`default_nettype none
// ============================================================================
// Module      : execute_mc
// Description : Pipelined EX stage with built-in EX/MEM register. Single-cycle
//               ALU and branch-target add; MUL iterates MUL_STEP multiplier
//               bits per cycle and stalls upstream while busy.
//               MUL_STEP must divide N.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_mc #(
  parameter int N        = 64,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  execute_mc_if.slave  bus
);

  localparam int                 ITER  = N / MUL_STEP;
  localparam int                 CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(ITER - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Captured MUL operands: a shifts left and b shifts right each iteration,
  // so the low MUL_STEP bits of b_q always weight the current a_q.
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] imm_q, imm_d;
  logic [N-1:0] wd_q, wd_d;

  logic         valid_m_q, valid_m_d;
  logic [N-1:0] pcb_m_q, pcb_m_d;
  logic [N-1:0] res_m_q, res_m_d;
  logic [N-1:0] wd_m_q, wd_m_d;
  logic         zero_m_q, zero_m_d;

  logic [N-1:0] b_sel;
  logic [N-1:0] alu_res;
  logic [N-1:0] b_step;
  logic [N-1:0] mul_res;

  assign b_sel   = bus.AluSrc ? bus.signImm_E : bus.readData2_E;

  // Multiplier slice for the current iteration, zero-extended to N bits
  if (MUL_STEP == N) begin : g_step_full
    assign b_step = b_q;
  end else begin : g_step_part
    assign b_step = {{(N-MUL_STEP){1'b0}}, b_q[MUL_STEP-1:0]};
  end

  assign mul_res = acc_q + (a_q * b_step);

  // Single-cycle ALU on the live operands
  always_comb begin
    alu_res = '0;
    case (bus.AluControl)
      ALU_AND:  alu_res = bus.readData1_E & b_sel;
      ALU_OR:   alu_res = bus.readData1_E | b_sel;
      ALU_ADD:  alu_res = bus.readData1_E + b_sel;
      ALU_SUB:  alu_res = bus.readData1_E - b_sel;
      ALU_PASS: alu_res = b_sel;
      ALU_NOR:  alu_res = ~(bus.readData1_E | b_sel);
      default:  alu_res = '0;
    endcase
  end

  // FSM state and iteration counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state, multiplier datapath and EX/MEM register contents
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    wd_d      = wd_q;
    valid_m_d = 1'b0;
    pcb_m_d   = pcb_m_q;
    res_m_d   = res_m_q;
    wd_m_d    = wd_m_q;
    zero_m_d  = zero_m_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_E && !bus.flush_E) begin
          if (bus.MulOp) begin
            state_d = S_BUSY;
            count_d = '0;
            acc_d   = '0;
            a_d     = bus.readData1_E;
            b_d     = b_sel;
            pc_d    = bus.PC_E;
            imm_d   = bus.signImm_E;
            wd_d    = bus.readData2_E;
          end else begin
            valid_m_d = 1'b1;
            res_m_d   = alu_res;
            zero_m_d  = (alu_res == '0);
            pcb_m_d   = bus.PC_E + (bus.signImm_E << 2);
            wd_m_d    = bus.readData2_E;
          end
        end
      end
      S_BUSY: begin
        if (bus.flush_E) begin
          state_d = S_IDLE;
          count_d = '0;
        end else begin
          acc_d   = mul_res;
          a_d     = a_q << MUL_STEP;
          b_d     = b_q >> MUL_STEP;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d   = S_IDLE;
            count_d   = '0;
            valid_m_d = 1'b1;
            res_m_d   = mul_res;
            zero_m_d  = (mul_res == '0);
            pcb_m_d   = pc_q + (imm_q << 2);
            wd_m_d    = wd_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Datapath and EX/MEM registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      wd_q      <= '0;
      valid_m_q <= 1'b0;
      pcb_m_q   <= '0;
      res_m_q   <= '0;
      wd_m_q    <= '0;
      zero_m_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      wd_q      <= wd_d;
      valid_m_q <= valid_m_d;
      pcb_m_q   <= pcb_m_d;
      res_m_q   <= res_m_d;
      wd_m_q    <= wd_m_d;
      zero_m_q  <= zero_m_d;
    end
  end

  // Stall: accepting a MUL, or any BUSY iteration but the last; flush releases it
  always_comb begin
    bus.stall_E = 1'b0;
    if (state_q == S_IDLE) begin
      bus.stall_E = bus.valid_E && bus.MulOp && !bus.flush_E;
    end else begin
      bus.stall_E = !bus.flush_E && (count_q != LAST);
    end
  end

  assign bus.valid_M     = valid_m_q;
  assign bus.PCBranch_M  = pcb_m_q;
  assign bus.aluResult_M = res_m_q;
  assign bus.writeData_M = wd_m_q;
  assign bus.zero_M      = zero_m_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_mc
// Description : Self-checking bench for execute_mc. Two instances (MUL_STEP=1
//               and MUL_STEP=4) share clock/reset; one is exercised at a time
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_mc;
  localparam int N = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  execute_mc_if #(.N(N)) bus1 ();
  execute_mc_if #(.N(N)) bus4 ();

  execute_mc #(.N(N), .MUL_STEP(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  execute_mc #(.N(N), .MUL_STEP(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  bit sel = 1'b0;   // 0: MUL_STEP=1 instance, 1: MUL_STEP=4 instance

  wire         obs_stall = sel ? bus4.stall_E     : bus1.stall_E;
  wire         obs_valid = sel ? bus4.valid_M     : bus1.valid_M;
  wire [N-1:0] obs_pcb   = sel ? bus4.PCBranch_M  : bus1.PCBranch_M;
  wire [N-1:0] obs_res   = sel ? bus4.aluResult_M : bus1.aluResult_M;
  wire [N-1:0] obs_wd    = sel ? bus4.writeData_M : bus1.writeData_M;
  wire         obs_zero  = sel ? bus4.zero_M      : bus1.zero_M;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
  endtask

  // Reference ALU from the operation table
  function automatic logic [N-1:0] alu_ref(input logic [3:0] ctl, input logic [N-1:0] a, input logic [N-1:0] b);
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic f, input logic src, input logic mul,
                        input logic [3:0] ctl, input logic [N-1:0] pc, input logic [N-1:0] imm,
                        input logic [N-1:0] a, input logic [N-1:0] b);
    if (sel) begin
      bus4.valid_E = v; bus4.flush_E = f; bus4.AluSrc = src; bus4.MulOp = mul;
      bus4.AluControl = ctl; bus4.PC_E = pc; bus4.signImm_E = imm;
      bus4.readData1_E = a; bus4.readData2_E = b;
    end else begin
      bus1.valid_E = v; bus1.flush_E = f; bus1.AluSrc = src; bus1.MulOp = mul;
      bus1.AluControl = ctl; bus1.PC_E = pc; bus1.signImm_E = imm;
      bus1.readData1_E = a; bus1.readData2_E = b;
    end
  endtask

  task automatic set_flush(input logic f);
    if (sel) bus4.flush_E = f;
    else     bus1.flush_E = f;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, '0, '0);
  endtask

  // Idle cycles: no result may appear
  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq("bubble_valid_M", obs_valid, 0);
      @(negedge clk);
    end
  endtask

  // Issue one instruction at a negedge and follow it to completion.
  // flush_at: -1 none, 0 flush alongside issue, k>0 flush in the k-th stall
  // cycle (BUSY iteration k-1).
  task automatic run_op(input logic src, input logic mul, input logic [3:0] ctl,
                        input logic [N-1:0] pc, input logic [N-1:0] imm,
                        input logic [N-1:0] a, input logic [N-1:0] b, input int flush_at);
    logic [N-1:0] bsel;
    logic [N-1:0] exp_res;
    int  iter;
    int  stalls;
    bit  flushed;
    bit  st;
    iter    = sel ? N/4 : N;
    bsel    = src ? imm : b;
    exp_res = mul ? (a * bsel) : alu_ref(ctl, a, bsel);
    set_in(1'b1, flush_at == 0, src, mul, ctl, pc, imm, a, b);
    stalls  = 0;
    flushed = 0;
    forever begin
      if (flush_at > 0 && stalls == flush_at) set_flush(1'b1);
      #1;
      st = obs_stall;
      if (flush_at == 0 || (flush_at > 0 && stalls == flush_at)) begin
        flushed = 1;
        check_eq("stall_in_flush", st, 0);
      end
      @(posedge clk); #1;
      if (!st || stalls > iter + 4) break;
      check_eq("busy_valid_M", obs_valid, 0);
      stalls++;
      @(negedge clk);
    end
    if (flushed) begin
      check_eq("flush_valid_M", obs_valid, 0);
    end else begin
      check_eq("stall_cycles", stalls, mul ? iter : 0);
      check_eq("valid_M", obs_valid, 1);
      check_eq("aluResult_M", obs_res, exp_res);
      check_eq("zero_M", obs_zero, exp_res == '0);
      check_eq("PCBranch_M", obs_pcb, pc + (imm << 2));
      check_eq("writeData_M", obs_wd, b);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic check_reset_state();
    check_eq("rst_valid_M", obs_valid, 0);
    check_eq("rst_aluResult_M", obs_res, 0);
    check_eq("rst_PCBranch_M", obs_pcb, 0);
    check_eq("rst_writeData_M", obs_wd, 0);
    check_eq("rst_zero_M", obs_zero, 0);
    check_eq("rst_stall_E", obs_stall, 0);
  endtask

  initial begin
    logic [3:0]   codes [7];
    logic [N-1:0] ra, rb, rimm, rpc;
    logic [3:0]   rctl;
    logic         rmul, rsrc;
    int           fa;

    sel = 1'b1; set_idle();
    sel = 1'b0; set_idle();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    sel = 1'b1; check_reset_state();
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // ADD and SUB producing zero
    run_op(1'b0, 1'b0, 4'b0010, 64'h1000, 64'h4, 64'd5, 64'd7, -1);
    run_op(1'b0, 1'b0, 4'b0110, 64'h2000, 64'h3, 64'd7, 64'd7, -1);

    // Reset held two cycles in the middle of a MUL
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 64'h40, 64'h1, 64'd9, 64'd11);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    set_idle();
    @(posedge clk); @(posedge clk); #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;
    bubble(3);
    run_op(1'b0, 1'b0, 4'b0010, 64'h80, 64'h2, 64'd20, 64'd22, -1);

    // Full-width MUL, one bit per iteration
    run_op(1'b0, 1'b1, 4'h0, 64'h100, 64'h5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, -1);

    // Four bits per iteration, with an ADD issued directly behind it
    sel = 1'b1;
    run_op(1'b0, 1'b1, 4'h0, 64'h200, 64'h1, 64'h1234, 64'h10, -1);
    run_op(1'b0, 1'b0, 4'b0010, 64'h204, 64'h1, 64'd1, 64'd2, -1);

    // Flush at BUSY iteration 10, then a fresh instruction
    sel = 1'b0;
    run_op(1'b0, 1'b1, 4'h0, 64'h300, 64'h1, 64'd123, 64'd456, 11);
    bubble(1);
    run_op(1'b1, 1'b0, 4'b0001, 64'h304, 64'hF0, 64'h0F, 64'd0, -1);

    // Branch-target wrap with an undefined ALU code
    run_op(1'b0, 1'b0, 4'b1010, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'hDEAD, 64'hBEEF, -1);

    // Flush dominating a MUL in IDLE
    run_op(1'b0, 1'b1, 4'h0, 64'h400, 64'h1, 64'd5, 64'd6, 0);

    // Randomised mix on both instances
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
    for (int i = 0; i < 120; i++) begin
      sel  = 1'($urandom_range(0, 1));
      rmul = ($urandom_range(0, 3) == 0);
      rsrc = 1'($urandom_range(0, 1));
      codes[6] = 4'($urandom);
      rctl = codes[$urandom_range(0, 6)];
      ra   = {$urandom, $urandom};
      rb   = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(0, 15));
      rimm = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($signed(32'($urandom)));
      if (rsrc && $urandom_range(0, 3) == 0) rimm = ra;
      rpc  = {$urandom, $urandom};
      fa   = -1;
      if ($urandom_range(0, 9) == 0) fa = 0;
      else if (rmul && $urandom_range(0, 5) == 0) fa = $urandom_range(1, (sel ? N/4 : N) - 1);
      run_op(rsrc, rmul, rctl, rpc, rimm, ra, rb, fa);
      bubble($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
